// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU dispatcher and its sub-units.
// Unit indices, logic-unit opcodes and the dispatcher state encoding.
package alu_pkg;

  localparam int UNIT_LOGIC = 0;
  localparam int UNIT_ARITH = 1;

  localparam logic [2:0] NOTA = 3'b000;
  localparam logic [2:0] NOTB = 3'b001;
  localparam logic [2:0] AND  = 3'b010;
  localparam logic [2:0] OR   = 3'b011;
  localparam logic [2:0] XOR  = 3'b100;
  localparam logic [2:0] NAND = 3'b101;
  localparam logic [2:0] NOR  = 3'b110;
  localparam logic [2:0] XNOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } disp_state_e;

endpackage

// File: rtl/alu_wait_timer.sv
// Clearable wait counter for the dispatcher.
// tc flags the cycle that completes TIMEOUT counted cycles.
module alu_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/alu_op_dispatch.sv
// Initiator side of the ALU start/finish handshake.
// One request in flight; result or timeout error returned on rsp port.
module alu_op_dispatch
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_unit,
  input  logic [2:0]                 req_op,
  input  logic [WIDTH-1:0]           req_a,
  input  logic [WIDTH-1:0]           req_b,
  output logic [NUM_UNITS-1:0]       unit_start,
  output logic [2:0]                 unit_op,
  output logic [WIDTH-1:0]           unit_a,
  output logic [WIDTH-1:0]           unit_b,
  input  logic [NUM_UNITS-1:0]       unit_finish,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_c,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_err
);

  disp_state_e          state_q, state_d;
  logic [1:0]           unit_q, unit_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [NUM_UNITS-1:0] start_q, start_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 err_q, err_d;

  logic                 sel_fin;
  logic [WIDTH-1:0]     sel_c;
  logic                 tmr_clr;
  logic                 tmr_en;
  logic                 tmr_tc;

  // Only the latched unit's finish/result are visible to the FSM.
  always_comb begin
    sel_fin = 1'b0;
    sel_c   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (unit_q == 2'(k)) begin
        sel_fin = unit_finish[k];
        sel_c   = unit_c[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    start_d = '0;
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          unit_d = req_unit;
          op_d   = req_op;
          a_d    = req_a;
          b_d    = req_b;
          if (int'(req_unit) < NUM_UNITS) begin
            state_d = START;
            for (int k = 0; k < NUM_UNITS; k++)
              start_d[k] = (req_unit == 2'(k));
          end else begin
            state_d = RESP;
            valid_d = 1'b1;
            data_d  = '0;
            err_d   = 1'b1;
          end
        end
      end
      START: begin
        state_d = WAIT;
        tmr_clr = 1'b1;
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (sel_fin) begin
          state_d = RESP;
          valid_d = 1'b1;
          data_d  = sel_c;
          err_d   = 1'b0;
        end else if (tmr_tc) begin
          state_d = RESP;
          valid_d = 1'b1;
          data_d  = '0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      unit_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      start_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      start_q <= start_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  alu_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .tc   (tmr_tc)
  );

  assign req_ready  = rst_n & (state_q == IDLE);
  assign unit_start = start_q;
  assign unit_op    = op_q;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign rsp_valid  = valid_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Directed bench for alu_op_dispatch with hand-computed expectations.
// The bench plays both the control path and the stub sub-units.
module tb_alu_op_dispatch;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int NU = 2;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_unit = '0;
  logic [2:0]    req_op = '0;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic [NU-1:0] unit_start;
  logic [2:0]    unit_op;
  logic [W-1:0]  unit_a;
  logic [W-1:0]  unit_b;
  logic [NU-1:0] unit_finish = '0;
  logic [NU*W-1:0] unit_c = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;

  int n_chk = 0;
  int n_pass = 0;

  alu_op_dispatch #(
    .WIDTH(W), .NUM_UNITS(NU), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_unit(req_unit), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .unit_start(unit_start), .unit_op(unit_op),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_finish(unit_finish), .unit_c(unit_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Present a request on a negedge; returns at the negedge after accept.
  task automatic send(input logic [1:0] u, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_unit  = u;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    chk("req_ready_pre", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ack_valid", 32'(rsp_valid), 32'd0);
    chk("ack_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic finish_unit(input int u, input logic [31:0] c);
    unit_finish = '0;
    unit_finish[u] = 1'b1;
    unit_c[u*W +: W] = c;
    @(negedge clk);
    unit_finish = '0;
  endtask

  initial begin
    int waits;
    int starts;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(unit_start), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_a", unit_a, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);

    send(2'd0, XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("xor_start", 32'(unit_start), 32'b01);
    chk("xor_op", 32'(unit_op), 32'(XOR));
    chk("xor_a", unit_a, 32'hF0F0_F0F0);
    chk("xor_b", unit_b, 32'hFF00_FF00);
    chk("xor_busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("xor_start_fell", 32'(unit_start), 32'd0);
    chk("xor_novalid", 32'(rsp_valid), 32'd0);
    finish_unit(0, 32'h0FF0_0FF0);
    chk("xor_valid", 32'(rsp_valid), 32'd1);
    chk("xor_data", rsp_data, 32'h0FF0_0FF0);
    chk("xor_err", 32'(rsp_err), 32'd0);
    ack();

    send(2'd1, 3'd0, 32'd1, 32'd2);
    starts = (unit_start != '0) ? 1 : 0;
    chk("to_start", 32'(unit_start), 32'b10);
    waits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      waits++;
      if (unit_start != '0) starts++;
    end
    chk("to_waits", 32'(waits), 32'(TO));
    chk("to_starts", 32'(starts), 32'd1);
    chk("to_valid", 32'(rsp_valid), 32'd1);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_data", rsp_data, 32'd0);
    ack();

    send(2'd3, 3'd2, 32'hAAAA_AAAA, 32'h5555_5555);
    chk("bad_start", 32'(unit_start), 32'd0);
    chk("bad_valid", 32'(rsp_valid), 32'd1);
    chk("bad_err", 32'(rsp_err), 32'd1);
    chk("bad_data", rsp_data, 32'd0);
    ack();

    send(2'd0, OR, 32'h1, 32'h2);
    @(negedge clk);
    finish_unit(1, 32'hDEAD_BEEF);
    chk("spur_novalid", 32'(rsp_valid), 32'd0);
    finish_unit(0, 32'h0000_1234);
    chk("spur_valid", 32'(rsp_valid), 32'd1);
    chk("spur_data", rsp_data, 32'h0000_1234);
    chk("spur_err", 32'(rsp_err), 32'd0);
    ack();

    unit_finish = 2'b01;
    repeat (3) begin
      @(negedge clk);
      chk("idle_fin_valid", 32'(rsp_valid), 32'd0);
      chk("idle_fin_ready", 32'(req_ready), 32'd1);
    end
    unit_finish = '0;

    send(2'd0, AND, 32'hFFFF_0000, 32'h0F0F_0F0F);
    @(negedge clk);
    finish_unit(0, 32'h0F0F_0000);
    repeat (5) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'h0F0F_0000);
      chk("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    ack();

    send(2'd1, 3'd1, 32'h0000_00FF, 32'h0000_0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 32'(req_ready), 32'd0);
    chk("mrst_op", 32'(unit_op), 32'd0);
    chk("mrst_a", unit_a, 32'd0);
    chk("mrst_b", unit_b, 32'd0);
    chk("mrst_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    finish_unit(1, 32'h0000_0100);
    chk("late_fin_valid", 32'(rsp_valid), 32'd0);
    chk("late_fin_ready", 32'(req_ready), 32'd1);

    send(2'd1, 3'd0, 32'd5, 32'd7);
    chk("post_start", 32'(unit_start), 32'b10);
    @(negedge clk);
    finish_unit(1, 32'd12);
    chk("post_valid", 32'(rsp_valid), 32'd1);
    chk("post_data", rsp_data, 32'd12);
    chk("post_err", 32'(rsp_err), 32'd0);
    ack();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
